la_capture_core: RTL and testbench



---
 rtl/la_pkg.sv | 19 +
 rtl/la_capture_core_if.sv | 13 +
 rtl/la_trigger_unit.sv | 37 +++
 rtl/la_capture_core.sv | 163 ++++++++++++++++
 tb/tb_la_capture_core.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/la_pkg.sv
// Shared types for the logic-analyzer capture engine.
package la_pkg;

    typedef enum logic [1:0] {
        LEVEL  = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2,
        CHANGE = 2'd3
    } trig_mode_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        WAIT = 3'd2,
        POST = 3'd3,
        DONE = 3'd4
    } state_e;

endpackage

// File: rtl/la_capture_core_if.sv
// Host/debug-bridge read port of the capture buffer.
interface la_capture_core_if #(
    parameter int PROBE_W = 32,
    parameter int ADDR_W  = 10
);
    logic               rd_req;
    logic [ADDR_W-1:0]  rd_addr;
    logic [PROBE_W-1:0] rd_data;
    logic               rd_valid;

    modport master (output rd_req, rd_addr, input rd_data, rd_valid);
    modport slave  (input rd_req, rd_addr, output rd_data, rd_valid);
endinterface

// File: rtl/la_trigger_unit.sv
// Trigger matcher: compares the live probe against latched config and the previous sample.
module la_trigger_unit
    import la_pkg::*;
#(
    parameter int PROBE_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PROBE_W-1:0] probe,
    input  trig_mode_e         mode,
    input  logic [PROBE_W-1:0] mask,
    input  logic [PROBE_W-1:0] value,
    output logic               hit
);

    logic [PROBE_W-1:0] prev_probe_q, prev_probe_d;

    // Tracking every cycle also covers the arm-time load, so edges never fire spuriously.
    always_comb prev_probe_d = probe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_probe_q <= '0;
        else        prev_probe_q <= prev_probe_d;
    end

    always_comb begin
        hit = 1'b0;
        case (mode)
            LEVEL:  hit = ((probe ^ value) & mask) == '0;
            RISE:   hit = |(probe & ~prev_probe_q & mask);
            FALL:   hit = |(~probe & prev_probe_q & mask);
            CHANGE: hit = |((probe ^ prev_probe_q) & mask);
            default: hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/la_capture_core.sv
// Circular-buffer capture engine with pre-trigger window and trigger-relative readout.
module la_capture_core
    import la_pkg::*;
#(
    parameter int PROBE_W = 32,
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PROBE_W-1:0] probe,
    input  logic               arm,
    input  logic               abort,
    input  logic [1:0]         trig_mode,
    input  logic [PROBE_W-1:0] trig_mask,
    input  logic [PROBE_W-1:0] trig_value,
    input  logic [ADDR_W-1:0]  pretrig_cnt,
    output logic               busy,
    output logic               triggered,
    output logic               done,
    output logic [ADDR_W-1:0]  trig_pos,
    la_capture_core_if.slave   rd
);

    logic [PROBE_W-1:0] mem [DEPTH];

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0]  pre_q, pre_d;
    trig_mode_e         mode_q, mode_d;
    logic [PROBE_W-1:0] mask_q, mask_d;
    logic [PROBE_W-1:0] value_q, value_d;
    logic [ADDR_W-1:0]  trig_pos_q, trig_pos_d;
    logic               triggered_q, triggered_d;
    logic [PROBE_W-1:0] rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;

    logic               we;
    logic               hit;
    logic [ADDR_W-1:0]  post_len;
    logic [ADDR_W-1:0]  rd_phys;

    la_trigger_unit #(.PROBE_W(PROBE_W)) u_trig (
        .clk   (clk),
        .rst_n (rst_n),
        .probe (probe),
        .mode  (mode_q),
        .mask  (mask_q),
        .value (value_q),
        .hit   (hit)
    );

    // pretrig_cnt is ADDR_W wide, so it can never exceed DEPTH-1: no explicit clamp needed.
    assign post_len = ADDR_W'(DEPTH - 1) - pre_q;
    assign rd_phys  = trig_pos_q - pre_q + rd.rd_addr;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        cnt_d       = cnt_q;
        pre_d       = pre_q;
        mode_d      = mode_q;
        mask_d      = mask_q;
        value_d     = value_q;
        trig_pos_d  = trig_pos_q;
        triggered_d = triggered_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        we          = 1'b0;

        if (abort) begin
            state_d     = IDLE;
            triggered_d = 1'b0;
        end else begin
            if (state_q == DONE && rd.rd_req) begin
                rd_valid_d = 1'b1;
                rd_data_d  = mem[rd_phys];
            end
            case (state_q)
                IDLE, DONE: begin
                    if (arm) begin
                        pre_d       = pretrig_cnt;
                        mode_d      = trig_mode_e'(trig_mode);
                        mask_d      = trig_mask;
                        value_d     = trig_value;
                        wr_ptr_d    = '0;
                        cnt_d       = '0;
                        triggered_d = 1'b0;
                        state_d     = (pretrig_cnt == '0) ? WAIT : PRE;
                    end
                end
                PRE: begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == pre_q - 1'b1) begin
                        cnt_d   = '0;
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (hit) begin
                        trig_pos_d  = wr_ptr_q;
                        triggered_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = (post_len == '0) ? DONE : POST;
                    end
                end
                POST: begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == post_len - 1'b1) state_d = DONE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            pre_q       <= '0;
            mode_q      <= LEVEL;
            mask_q      <= '0;
            value_q     <= '0;
            trig_pos_q  <= '0;
            triggered_q <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            pre_q       <= pre_d;
            mode_q      <= mode_d;
            mask_q      <= mask_d;
            value_q     <= value_d;
            trig_pos_q  <= trig_pos_d;
            triggered_q <= triggered_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    // Sample storage carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) mem[wr_ptr_q] <= probe;
    end

    assign busy        = (state_q == PRE) || (state_q == WAIT) || (state_q == POST);
    assign done        = (state_q == DONE);
    assign triggered   = triggered_q;
    assign trig_pos    = trig_pos_q;
    assign rd.rd_data  = rd_data_q;
    assign rd.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_la_capture_core.sv
// Scoreboard bench for la_capture_core at DEPTH=16, PROBE_W=8 with a counting probe.
module tb_la_capture_core;
    import la_pkg::*;

    localparam int PW = 8;
    localparam int D  = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [PW-1:0] probe = '0;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic [1:0]    trig_mode = 2'd0;
    logic [PW-1:0] trig_mask = '0;
    logic [PW-1:0] trig_value = '0;
    logic [AW-1:0] pretrig_cnt = '0;
    logic          busy, triggered, done;
    logic [AW-1:0] trig_pos;

    la_capture_core_if #(.PROBE_W(PW), .ADDR_W(AW)) rif ();

    la_capture_core #(.PROBE_W(PW), .DEPTH(D)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .probe       (probe),
        .arm         (arm),
        .abort       (abort),
        .trig_mode   (trig_mode),
        .trig_mask   (trig_mask),
        .trig_value  (trig_value),
        .pretrig_cnt (pretrig_cnt),
        .busy        (busy),
        .triggered   (triggered),
        .done        (done),
        .trig_pos    (trig_pos),
        .rd          (rif.slave)
    );

    always #5 clk = ~clk;

    int            total = 0;
    int            bad = 0;
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] e;
    bit            toggle = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; the probe changes just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        probe = toggle ? (probe ^ 8'h01) : (probe + 8'h01);
    endtask

    task automatic arm_cap(input logic [1:0] m, input logic [7:0] mask,
                           input logic [7:0] val, input logic [3:0] pre);
        trig_mode   = m;
        trig_mask   = mask;
        trig_value  = val;
        pretrig_cnt = pre;
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 300) begin
            step();
            n++;
        end
        check(name, {31'd0, done}, 32'd1);
    endtask

    // Read logical 0..15; expected is first+i, or alternating 1/0 for the toggle pattern.
    task automatic read_all(input logic [7:0] first, input bit alt);
        for (int i = 0; i < D; i++) begin
            rif.rd_req  = 1'b1;
            rif.rd_addr = AW'(i);
            exp_q.push_back(alt ? ((i % 2 == 0) ? 8'h01 : 8'h00) : first + 8'(i));
            step();
        end
        rif.rd_req = 1'b0;
        step();
        step();
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    task automatic level_capture(input bit mid_arm);
        probe = 8'h10;
        arm_cap(2'd0, 8'hFF, 8'h40, 4'd4);
        if (mid_arm) begin
            repeat (6) step();
            check("busy_before_rearm", {31'd0, busy}, 32'd1);
            arm_cap(2'd3, 8'hFF, 8'h15, 4'd0);
        end
        wait_done("level_done");
        check("level_triggered", {31'd0, triggered}, 32'd1);
        check("level_busy", {31'd0, busy}, 32'd0);
        check("level_trig_pos", {28'd0, trig_pos}, 32'd15);
        read_all(8'h3C, 1'b0);
    endtask

    initial begin
        fork
            begin
                forever begin
                    @(negedge clk);
                    if (rif.rd_valid) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_rd_valid", {31'd0, rif.rd_valid}, 32'd0);
                        end else begin
                            e = exp_q.pop_front();
                            check("rd_data", {24'd0, rif.rd_data}, {24'd0, e});
                        end
                    end
                end
            end
            begin
                rif.rd_req  = 1'b0;
                rif.rd_addr = '0;
                step();
                step();
                check("rst_busy", {31'd0, busy}, 32'd0);
                check("rst_triggered", {31'd0, triggered}, 32'd0);
                check("rst_done", {31'd0, done}, 32'd0);
                check("rst_trig_pos", {28'd0, trig_pos}, 32'd0);
                check("rst_rd_valid", {31'd0, rif.rd_valid}, 32'd0);
                check("rst_rd_data", {24'd0, rif.rd_data}, 32'd0);
                rst_n = 1'b1;
                step();

                // LEVEL, pre=4, trigger on 0x40
                level_capture(1'b0);

                // RISE on bit0 with the probe high at arm: the first rise is one sample later
                toggle = 1'b1;
                probe  = 8'h01;
                arm_cap(2'd1, 8'h01, 8'h00, 4'd0);
                wait_done("rise_done");
                check("rise_trig_pos", {28'd0, trig_pos}, 32'd1);
                read_all(8'h00, 1'b1);
                toggle = 1'b0;

                // Full pre-trigger window: trigger is the last sample, buffer wraps
                probe = 8'h20;
                arm_cap(2'd0, 8'hFF, 8'h40, 4'd15);
                wait_done("clamp_done");
                check("clamp_trig_pos", {28'd0, trig_pos}, 32'd15);
                read_all(8'h31, 1'b0);

                // LEVEL with mask 0 fires on the first WAIT sample
                probe = 8'h50;
                arm_cap(2'd0, 8'h00, 8'hAA, 4'd0);
                wait_done("mask0_level_done");
                check("mask0_level_trig_pos", {28'd0, trig_pos}, 32'd0);
                read_all(8'h51, 1'b0);

                // CHANGE with mask 0 never fires
                arm_cap(2'd3, 8'h00, 8'h00, 4'd0);
                repeat (40) step();
                check("mask0_change_busy", {31'd0, busy}, 32'd1);
                check("mask0_change_done", {31'd0, done}, 32'd0);
                check("mask0_change_trig", {31'd0, triggered}, 32'd0);
                abort = 1'b1;
                step();
                abort = 1'b0;

                // Abort in POST, then reads in IDLE must stay silent
                probe = 8'h60;
                arm_cap(2'd0, 8'hFF, 8'h66, 4'd2);
                for (int n = 0; n < 50 && !triggered; n++) step();
                check("abort_pre_triggered", {31'd0, triggered}, 32'd1);
                step();
                check("abort_pre_busy", {31'd0, busy}, 32'd1);
                abort = 1'b1;
                step();
                abort = 1'b0;
                check("abort_busy", {31'd0, busy}, 32'd0);
                check("abort_triggered", {31'd0, triggered}, 32'd0);
                check("abort_done", {31'd0, done}, 32'd0);
                rif.rd_req  = 1'b1;
                rif.rd_addr = 4'd3;
                repeat (3) step();
                rif.rd_req = 1'b0;
                check("idle_rd_valid", {31'd0, rif.rd_valid}, 32'd0);
                level_capture(1'b0);

                // Asynchronous reset in the middle of WAIT
                arm_cap(2'd0, 8'hFF, probe - 8'h02, 4'd0);
                repeat (5) step();
                check("wait_busy", {31'd0, busy}, 32'd1);
                #2;
                rst_n = 1'b0;
                #1;
                check("arst_busy", {31'd0, busy}, 32'd0);
                check("arst_triggered", {31'd0, triggered}, 32'd0);
                check("arst_done", {31'd0, done}, 32'd0);
                check("arst_trig_pos", {28'd0, trig_pos}, 32'd0);
                check("arst_rd_data", {24'd0, rif.rd_data}, 32'd0);
                check("arst_rd_valid", {31'd0, rif.rd_valid}, 32'd0);
                step();
                rst_n = 1'b1;
                step();

                // A second arm while busy must not disturb the running capture
                level_capture(1'b1);
            end
        join_any
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
